// File: rtl/conv_accum_lane.sv
// One MAC lane of the convolution engine: accumulates NUM_TERMS signed products
// into a saturating accumulator and holds the result until acknowledged.
module conv_accum_lane #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned NUM_TERMS = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ack,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [ACC_W-1:0]  acc_out,
  output logic              done,
  output logic              ovf
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned CNT_W  = $clog2(NUM_TERMS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                    state, state_next;
  logic [CNT_W-1:0]          count;
  logic signed [PROD_W-1:0]  prod, prod_c;
  logic                      prod_valid;
  logic                      accept, last_beat;
  logic signed [SUM_W-1:0]   sum;
  logic                      sat_hi, sat_lo;
  logic [ACC_W-1:0]          acc_next;

  // Beat acceptance, product and saturating add (one guard bit detects overflow)
  always_comb begin
    accept    = in_valid & in_ready & ~start;
    last_beat = accept && (count == CNT_W'(NUM_TERMS - 1));
    prod_c    = PROD_W'($signed(in_a)) * PROD_W'($signed(in_b));
    sum       = SUM_W'($signed(acc_out)) + SUM_W'(prod);
    sat_hi    = ~sum[SUM_W-1] &  sum[SUM_W-2];
    sat_lo    =  sum[SUM_W-1] & ~sum[SUM_W-2];
    acc_next  = sum[ACC_W-1:0];
    if (sat_hi) begin
      acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    end else if (sat_lo) begin
      acc_next = {1'b1, {(ACC_W-1){1'b0}}};
    end
  end

  // Next-state logic; start overrides everything, DRAIN waits for the pipeline to empty
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ACCUM;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        ACCUM:   if (last_beat) state_next = DRAIN;
        DRAIN:   if (!prod_valid) state_next = DONE;
        DONE:    if (ack) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      acc_out    <= '0;
      ovf        <= 1'b0;
      in_ready   <= 1'b0;
      done       <= 1'b0;
    end else begin
      in_ready <= (state_next == ACCUM);
      done     <= (state_next == DONE);
      if (start) begin
        count      <= '0;
        prod_valid <= 1'b0;
        acc_out    <= '0;
        ovf        <= 1'b0;
      end else begin
        prod_valid <= accept;
        if (accept) begin
          count <= count + CNT_W'(1);
          prod  <= prod_c;
        end
        if (prod_valid) begin
          acc_out <= acc_next;
          ovf     <= ovf | sat_hi | sat_lo;
        end
      end
    end
  end

endmodule
